// File: rtl/mem_unit_if.sv
// Handshake bundle between an initiator (MAR/MDR side) and the mem_unit responder.
interface mem_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              memEn;
  logic              R_W;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] dataOut;
  logic              MFC;
  logic              busy;

  modport master (
    output memEn, R_W, addr, dataIn,
    input  dataOut, MFC, busy
  );

  modport slave (
    input  memEn, R_W, addr, dataIn,
    output dataOut, MFC, busy
  );
endinterface

// File: rtl/mem_unit.sv
// Memory responder: captures a request on memEn, waits WAIT_CYCLES, performs the
// access on an internal word array and holds MFC until the initiator drops memEn.
module mem_unit #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic     clk,
  input  logic     reset,
  mem_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_dout;
  logic              r_mfc;
  logic              w_mfc_nxt;
  logic              w_cap;
  logic              w_we;
  logic              w_rd;

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mfc_nxt   = r_mfc;
    w_cap       = 1'b0;
    w_we        = 1'b0;
    w_rd        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.memEn) begin
          w_cap       = 1'b1;
          w_cnt_nxt   = 4'(WAIT_CYCLES);
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.memEn) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_rd        = r_rw;
          w_we        = ~r_rw;
          w_mfc_nxt   = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (!bus.memEn) begin
          w_mfc_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_mfc_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_data  <= '0;
      r_mfc   <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mfc   <= w_mfc_nxt;
      if (w_cap) begin
        r_addr <= bus.addr;
        r_rw   <= bus.R_W;
        r_data <= bus.dataIn;
      end
      if (w_rd) begin
        r_dout <= r_mem[r_addr];
      end
    end
  end

  // Array has no reset; the write enable is gated by reset so an edge coincident
  // with reset assertion can never commit a pending write.
  always_ff @(posedge clk) begin
    if (w_we && reset) begin
      r_mem[r_addr] <= r_data;
    end
  end

  assign bus.dataOut = r_dout;
  assign bus.MFC     = r_mfc;
  assign bus.busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_unit.sv
// Bench for mem_unit: a transaction-timing model checked every cycle, plus directed literal checks.
module tb_mem_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_unit_if #(.ADDR_W(8), .DATA_W(16)) bus0 ();
  mem_unit_if #(.ADDR_W(8), .DATA_W(16)) bus1 ();

  mem_unit #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(rst_n), .bus(bus0));
  mem_unit #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .bus(bus1));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Model: a transaction is "active" from its capture edge; the access happens
  // WAIT+1 edges after capture if memEn is still held, and ends when memEn is seen low.
  bit          m_active [2];
  int          m_age    [2];
  logic [7:0]  m_addr   [2];
  bit          m_rw     [2];
  logic [15:0] m_wdat   [2];
  bit          m_mfc    [2];
  logic [15:0] m_dout   [2];
  logic [15:0] m_mem    [2][256];
  bit          m_vld    [2][256];

  task automatic model_step(input int k, input int w, input logic en, input logic rw,
                            input logic [7:0] a, input logic [15:0] d);
    if (!rst_n) begin
      m_active[k] = 0; m_mfc[k] = 0; m_dout[k] = '0;
    end else if (!m_active[k]) begin
      if (en) begin
        m_active[k] = 1; m_age[k] = 0; m_addr[k] = a; m_rw[k] = rw; m_wdat[k] = d;
      end
    end else if (!en) begin
      m_active[k] = 0; m_mfc[k] = 0;
    end else if (!m_mfc[k]) begin
      m_age[k]++;
      if (m_age[k] == w + 1) begin
        m_mfc[k] = 1;
        if (m_rw[k]) m_dout[k] = m_vld[k][m_addr[k]] ? m_mem[k][m_addr[k]] : 16'hxxxx;
        else begin
          m_mem[k][m_addr[k]] = m_wdat[k];
          m_vld[k][m_addr[k]] = 1;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    model_step(0, 2, bus0.memEn, bus0.R_W, bus0.addr, bus0.dataIn);
    model_step(1, 0, bus1.memEn, bus1.R_W, bus1.addr, bus1.dataIn);
  end

  always @(negedge clk) begin
    chk("cmp0_dataOut", bus0.dataOut, m_dout[0]);
    chk("cmp0_MFC", {15'd0, bus0.MFC}, {15'd0, m_mfc[0]});
    chk("cmp0_busy", {15'd0, bus0.busy}, {15'd0, m_active[0]});
    chk("cmp1_dataOut", bus1.dataOut, m_dout[1]);
    chk("cmp1_MFC", {15'd0, bus1.MFC}, {15'd0, m_mfc[1]});
    chk("cmp1_busy", {15'd0, bus1.busy}, {15'd0, m_active[1]});
  end

  task automatic set_en(input int k, input logic v);
    if (k == 0) bus0.memEn = v; else bus1.memEn = v;
  endtask

  task automatic set_req(input int k, input logic rw, input logic [7:0] a, input logic [15:0] d);
    if (k == 0) begin bus0.R_W = rw; bus0.addr = a; bus0.dataIn = d; end
    else        begin bus1.R_W = rw; bus1.addr = a; bus1.dataIn = d; end
  endtask

  task automatic samp(input int k, output logic m, output logic b, output logic [15:0] d);
    if (k == 0) begin m = bus0.MFC; b = bus0.busy; d = bus0.dataOut; end
    else        begin m = bus1.MFC; b = bus1.busy; d = bus1.dataOut; end
  endtask

  // Full transaction; lat = edges from capture edge to the edge where MFC is first seen.
  task automatic xact(input int k, input logic rw, input logic [7:0] a, input logic [15:0] d,
                      input int hold, input logic [15:0] hold_exp, input bit scramble,
                      output int lat, output logic [15:0] rd, output time t0);
    logic m, b;
    logic [15:0] dq;
    bit got;
    @(negedge clk);
    set_req(k, rw, a, d);
    set_en(k, 1'b1);
    @(posedge clk);
    t0 = $time;
    if (scramble) begin
      @(negedge clk);
      set_req(k, 1'b0, a + 8'd1, 16'hDEAD);
    end
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      samp(k, m, b, dq);
      chk("busy_in_xact", {15'd0, b}, 16'd1);
      if (m) got = 1;
    end
    chk("mfc_seen", {15'd0, got}, 16'd1);
    rd = dq;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      samp(k, m, b, dq);
      chk("hold_MFC", {15'd0, m}, 16'd1);
      chk("hold_dataOut", dq, hold_exp);
    end
    @(negedge clk);
    set_en(k, 1'b0);
    @(posedge clk); #1;
    samp(k, m, b, dq);
    chk("mfc_fall", {15'd0, m}, 16'd0);
    chk("busy_fall", {15'd0, b}, 16'd0);
  endtask

  initial begin
    int lat, lat2;
    logic [15:0] rd;
    logic m, b;
    logic [15:0] dq;
    time t0, t1;

    set_en(0, 1'b0); set_en(1, 1'b0);
    set_req(0, 1'b1, 8'h00, 16'h0000);
    set_req(1, 1'b1, 8'h00, 16'h0000);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    samp(0, m, b, dq);
    chk("rst_MFC", {15'd0, m}, 16'd0);
    chk("rst_busy", {15'd0, b}, 16'd0);
    chk("rst_dataOut", dq, 16'h0000);
    rst_n = 1'b1;

    xact(0, 1'b0, 8'h05, 16'h1234, 0, 16'h0, 0, lat, rd, t0);
    xact(0, 1'b0, 8'h01, 16'h1111, 0, 16'h0, 0, lat, rd, t0);
    xact(0, 1'b0, 8'h02, 16'h2222, 0, 16'h0, 0, lat, rd, t0);
    xact(0, 1'b0, 8'h20, 16'h0F0F, 0, 16'h0, 0, lat, rd, t0);
    xact(0, 1'b0, 8'h30, 16'h3333, 0, 16'h0, 0, lat, rd, t0);

    // Write then read 0x12
    xact(0, 1'b0, 8'h12, 16'hBEEF, 0, 16'h0, 0, lat, rd, t0);
    chk("wr_latency", 16'(lat), 16'd3);
    xact(0, 1'b1, 8'h12, 16'h0000, 0, 16'h0, 0, lat, rd, t0);
    chk("rd_latency", 16'(lat), 16'd3);
    chk("rd_BEEF", rd, 16'hBEEF);

    // Stretched handshake
    xact(0, 1'b1, 8'h05, 16'h0000, 10, 16'h1234, 0, lat, rd, t0);
    chk("stretch_data", rd, 16'h1234);

    // Abort during WAIT
    @(negedge clk);
    set_req(0, 1'b0, 8'h20, 16'hAAAA);
    set_en(0, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    samp(0, m, b, dq);
    chk("abort_MFC_wait", {15'd0, m}, 16'd0);
    chk("abort_busy_wait", {15'd0, b}, 16'd1);
    @(negedge clk);
    set_en(0, 1'b0);
    @(posedge clk); #1;
    samp(0, m, b, dq);
    chk("abort_MFC", {15'd0, m}, 16'd0);
    chk("abort_idle", {15'd0, b}, 16'd0);
    xact(0, 1'b1, 8'h20, 16'h0000, 0, 16'h0, 0, lat, rd, t0);
    chk("abort_old_data", rd, 16'h0F0F);

    // Capture isolation
    xact(0, 1'b1, 8'h01, 16'h0000, 0, 16'h0, 1, lat, rd, t0);
    chk("iso_read", rd, 16'h1111);
    xact(0, 1'b1, 8'h02, 16'h0000, 0, 16'h0, 0, lat, rd, t0);
    chk("iso_no_write", rd, 16'h2222);

    // Reset in WAIT of a write
    @(negedge clk);
    set_req(0, 1'b0, 8'h30, 16'h5555);
    set_en(0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    samp(0, m, b, dq);
    chk("midrst_MFC", {15'd0, m}, 16'd0);
    chk("midrst_busy", {15'd0, b}, 16'd0);
    chk("midrst_dataOut", dq, 16'h0000);
    set_en(0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xact(0, 1'b1, 8'h30, 16'h0000, 0, 16'h0, 0, lat, rd, t0);
    chk("rst_no_write", rd, 16'h3333);

    // WAIT_CYCLES = 0, back-to-back reads
    xact(1, 1'b0, 8'h40, 16'hCAFE, 0, 16'h0, 0, lat, rd, t0);
    xact(1, 1'b0, 8'h41, 16'h0BAD, 0, 16'h0, 0, lat, rd, t0);
    xact(1, 1'b1, 8'h40, 16'h0000, 0, 16'h0, 0, lat, rd, t0);
    chk("w0_lat_a", 16'(lat), 16'd1);
    chk("w0_data_a", rd, 16'hCAFE);
    xact(1, 1'b1, 8'h41, 16'h0000, 0, 16'h0, 0, lat2, rd, t1);
    chk("w0_lat_b", 16'(lat2), 16'd1);
    chk("w0_data_b", rd, 16'h0BAD);
    chk("w0_spacing", 16'((t1 - t0) / 10), 16'd3);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
